packetmem_nbuf: RTL and testbench

PACKETMEM_NBUF -- requirements
Module: packetmem_nbuf

---
 rtl/packetmem_pkg.sv | 5 +
 rtl/packetram.sv | 18 +
 rtl/packetmem_nbuf.sv | 158 +++++++++++++++
 tb/tb_packetmem_nbuf.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packetmem_pkg.sv
// packetmem_pkg: buffer ownership states and CPU transfer-size codes
package packetmem_pkg;
  typedef enum logic [1:0] {BUF_FREE, BUF_FILLED, BUF_ACCEPTED, BUF_REJECTED} buf_state_e;
  typedef enum logic [1:0] {TSZ_BYTE, TSZ_HALF, TSZ_WORD, TSZ_RSVD} xfer_sz_e;
endpackage

// File: rtl/packetram.sv
// packetram: simple dual-port RAM, one write port and one registered read port
module packetram #(
  parameter int AW = 9,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/packetmem_nbuf.sv
// packetmem_nbuf: ring of packet buffers handed snooper -> CPU -> forwarder in arrival order
module packetmem_nbuf
  import packetmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BUFS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] snooper_wr_addr,
  input  logic [63:0]           snooper_wr_data,
  input  logic                  snooper_wr_en,
  input  logic                  snooper_done,
  input  logic [ADDR_WIDTH+3:0] snooper_len,
  output logic                  snooper_ready,
  input  logic [ADDR_WIDTH+2:0] cpu_byte_rd_addr,
  input  logic [1:0]            transfer_sz,
  input  logic                  cpu_rd_en,
  output logic [31:0]           cpu_rd_data,
  output logic                  cpu_rd_valid,
  output logic                  cpu_pkt_avail,
  output logic [ADDR_WIDTH+3:0] cpu_len,
  input  logic                  cpu_acc,
  input  logic                  cpu_rej,
  input  logic [ADDR_WIDTH-1:0] fwd_rd_addr,
  input  logic                  fwd_rd_en,
  output logic [63:0]           fwd_rd_data,
  output logic                  fwd_rd_valid,
  output logic                  fwd_pkt_avail,
  output logic [ADDR_WIDTH+3:0] fwd_len,
  input  logic                  fwd_done
);
  localparam int PW = $clog2(NUM_BUFS);
  localparam int BW = ADDR_WIDTH - 1;
  localparam int LW = ADDR_WIDTH + 4;
  buf_state_e st_q [NUM_BUFS];
  buf_state_e st_d [NUM_BUFS];
  logic [LW-1:0] len_q [NUM_BUFS];
  logic [LW-1:0] len_d [NUM_BUFS];
  logic [PW-1:0] snoop_ptr_q, snoop_ptr_d, cpu_ptr_q, cpu_ptr_d, fwd_ptr_q, fwd_ptr_d;
  logic snoop_ev, cpu_ev, fwd_ev, wr_ok;
  logic [ADDR_WIDTH-1:0] cpu_word;
  logic [BW-1:0] ra_ev [NUM_BUFS];
  logic [BW-1:0] ra_od [NUM_BUFS];
  logic [63:0] rd_ev [NUM_BUFS];
  logic [63:0] rd_od [NUM_BUFS];
  logic [NUM_BUFS-1:0] we_ev, we_od, cpu_sel;
  logic c1_v_q, c1_own_q, c1_par_q, f1_v_q, f1_own_q, f1_par_q;
  logic [PW-1:0] c1_ptr_q, f1_ptr_q;
  logic [2:0] c1_off_q;
  xfer_sz_e c1_tsz_q;
  logic [127:0] pair;
  logic [6:0] sel;
  logic [31:0] w32, ext, cpu_rd_data_q;
  logic cpu_rd_valid_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NUM_BUFS - 1)) ? '0 : p + PW'(1);
  endfunction
  assign snooper_ready = st_q[snoop_ptr_q] == BUF_FREE;
  assign cpu_pkt_avail = st_q[cpu_ptr_q] == BUF_FILLED;
  assign fwd_pkt_avail = st_q[fwd_ptr_q] == BUF_ACCEPTED;
  assign cpu_len = cpu_pkt_avail ? len_q[cpu_ptr_q] : '0;
  assign fwd_len = fwd_pkt_avail ? len_q[fwd_ptr_q] : '0;
  assign snoop_ev = snooper_done & snooper_ready;
  assign cpu_ev = (cpu_acc | cpu_rej) & cpu_pkt_avail;
  // A rejected buffer is recycled silently as soon as the forwarder reaches it
  assign fwd_ev = (fwd_done & fwd_pkt_avail) | (st_q[fwd_ptr_q] == BUF_REJECTED);
  assign wr_ok = snooper_wr_en & snooper_ready;
  assign cpu_word = cpu_byte_rd_addr[ADDR_WIDTH+2:3];
  always_comb begin
    for (int i = 0; i < NUM_BUFS; i++) begin
      st_d[i] = st_q[i];
      len_d[i] = len_q[i];
      if (snoop_ev && snoop_ptr_q == PW'(i)) begin
        st_d[i] = BUF_FILLED;
        len_d[i] = snooper_len;
      end
      if (cpu_ev && cpu_ptr_q == PW'(i)) st_d[i] = cpu_rej ? BUF_REJECTED : BUF_ACCEPTED;
      if (fwd_ev && fwd_ptr_q == PW'(i)) st_d[i] = BUF_FREE;
    end
    snoop_ptr_d = snoop_ev ? nxt(snoop_ptr_q) : snoop_ptr_q;
    cpu_ptr_d = cpu_ev ? nxt(cpu_ptr_q) : cpu_ptr_q;
    fwd_ptr_d = fwd_ev ? nxt(fwd_ptr_q) : fwd_ptr_q;
  end
  // Odd word w: w+1 lives in the even bank one row up, so a straddling read hits both banks at once
  always_comb begin
    for (int i = 0; i < NUM_BUFS; i++) begin
      cpu_sel[i] = cpu_pkt_avail && cpu_ptr_q == PW'(i);
      ra_ev[i] = cpu_sel[i] ? cpu_word[ADDR_WIDTH-1:1] + BW'(cpu_word[0]) : fwd_rd_addr[ADDR_WIDTH-1:1];
      ra_od[i] = cpu_sel[i] ? cpu_word[ADDR_WIDTH-1:1] : fwd_rd_addr[ADDR_WIDTH-1:1];
      we_ev[i] = wr_ok && snoop_ptr_q == PW'(i) && !snooper_wr_addr[0];
      we_od[i] = wr_ok && snoop_ptr_q == PW'(i) && snooper_wr_addr[0];
    end
  end
  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
    packetram #(.AW(BW)) u_ev (
      .clk(clk), .we_i(we_ev[g]), .waddr_i(snooper_wr_addr[ADDR_WIDTH-1:1]),
      .wdata_i(snooper_wr_data), .raddr_i(ra_ev[g]), .rdata_o(rd_ev[g])
    );
    packetram #(.AW(BW)) u_od (
      .clk(clk), .we_i(we_od[g]), .waddr_i(snooper_wr_addr[ADDR_WIDTH-1:1]),
      .wdata_i(snooper_wr_data), .raddr_i(ra_od[g]), .rdata_o(rd_od[g])
    );
  end
  always_comb begin
    pair = c1_par_q ? {rd_od[c1_ptr_q], rd_ev[c1_ptr_q]} : {rd_ev[c1_ptr_q], rd_od[c1_ptr_q]};
    sel = 7'd96 - {1'b0, c1_off_q, 3'b000};
    w32 = pair[sel +: 32];
    ext = c1_tsz_q == TSZ_WORD ? w32 :
          c1_tsz_q == TSZ_HALF ? {16'h0, w32[31:16]} :
          c1_tsz_q == TSZ_BYTE ? {24'h0, w32[31:24]} : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        st_q[i] <= BUF_FREE;
        len_q[i] <= '0;
      end
      snoop_ptr_q <= '0;
      cpu_ptr_q <= '0;
      fwd_ptr_q <= '0;
      c1_v_q <= 1'b0;
      c1_own_q <= 1'b0;
      c1_par_q <= 1'b0;
      c1_ptr_q <= '0;
      c1_off_q <= '0;
      c1_tsz_q <= TSZ_BYTE;
      f1_v_q <= 1'b0;
      f1_own_q <= 1'b0;
      f1_par_q <= 1'b0;
      f1_ptr_q <= '0;
      cpu_rd_valid_q <= 1'b0;
      cpu_rd_data_q <= '0;
    end else begin
      st_q <= st_d;
      len_q <= len_d;
      snoop_ptr_q <= snoop_ptr_d;
      cpu_ptr_q <= cpu_ptr_d;
      fwd_ptr_q <= fwd_ptr_d;
      c1_v_q <= cpu_rd_en;
      c1_own_q <= cpu_rd_en & cpu_pkt_avail;
      c1_par_q <= cpu_word[0];
      c1_ptr_q <= cpu_ptr_q;
      c1_off_q <= cpu_byte_rd_addr[2:0];
      c1_tsz_q <= xfer_sz_e'(transfer_sz);
      f1_v_q <= fwd_rd_en;
      f1_own_q <= fwd_rd_en & fwd_pkt_avail;
      f1_par_q <= fwd_rd_addr[0];
      f1_ptr_q <= fwd_ptr_q;
      cpu_rd_valid_q <= c1_v_q;
      cpu_rd_data_q <= c1_own_q ? ext : '0;
    end
  end
  assign cpu_rd_data = cpu_rd_data_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign fwd_rd_valid = f1_v_q;
  assign fwd_rd_data = f1_own_q ? (f1_par_q ? rd_od[f1_ptr_q] : rd_ev[f1_ptr_q]) : '0;
endmodule

// File: tb/tb_packetmem_nbuf.sv
// tb_packetmem_nbuf: directed scenarios plus random traffic against a byte-level ownership model
module tb_packetmem_nbuf;
  localparam int AW = 10;
  localparam int NB = 3;
  localparam int LW = AW + 4;
  localparam int NBYTES = 8 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] snooper_wr_addr = '0;
  logic [63:0] snooper_wr_data = '0;
  logic snooper_wr_en = 1'b0, snooper_done = 1'b0;
  logic [LW-1:0] snooper_len = '0;
  logic snooper_ready;
  logic [AW+2:0] cpu_byte_rd_addr = '0;
  logic [1:0] transfer_sz = '0;
  logic cpu_rd_en = 1'b0;
  logic [31:0] cpu_rd_data;
  logic cpu_rd_valid, cpu_pkt_avail;
  logic [LW-1:0] cpu_len;
  logic cpu_acc = 1'b0, cpu_rej = 1'b0;
  logic [AW-1:0] fwd_rd_addr = '0;
  logic fwd_rd_en = 1'b0;
  logic [63:0] fwd_rd_data;
  logic fwd_rd_valid, fwd_pkt_avail;
  logic [LW-1:0] fwd_len;
  logic fwd_done = 1'b0;
  int checks = 0;
  int errors = 0;
  // model: 0 free, 1 filled, 2 accepted, 3 rejected; memory kept as plain bytes
  int st[NB];
  int sp = 0, cp = 0, fp = 0;
  logic [LW-1:0] len_m[NB];
  logic [7:0] mem_m[NB][NBYTES];

  always #5 clk = ~clk;

  packetmem_nbuf #(.ADDR_WIDTH(AW), .NUM_BUFS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .snooper_len(snooper_len), .snooper_ready(snooper_ready),
    .cpu_byte_rd_addr(cpu_byte_rd_addr), .transfer_sz(transfer_sz),
    .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
    .cpu_pkt_avail(cpu_pkt_avail), .cpu_len(cpu_len), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .fwd_rd_addr(fwd_rd_addr), .fwd_rd_en(fwd_rd_en), .fwd_rd_data(fwd_rd_data),
    .fwd_rd_valid(fwd_rd_valid), .fwd_pkt_avail(fwd_pkt_avail), .fwd_len(fwd_len),
    .fwd_done(fwd_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ready"}, 64'(snooper_ready), 64'(st[sp] == 0));
    chk({tag, ".cpu_avail"}, 64'(cpu_pkt_avail), 64'(st[cp] == 1));
    chk({tag, ".cpu_len"}, 64'(cpu_len), st[cp] == 1 ? 64'(len_m[cp]) : 64'h0);
    chk({tag, ".fwd_avail"}, 64'(fwd_pkt_avail), 64'(st[fp] == 2));
    chk({tag, ".fwd_len"}, 64'(fwd_len), st[fp] == 2 ? 64'(len_m[fp]) : 64'h0);
  endtask

  task automatic cycle();
    bit sev, cev, fev, rej;
    logic [LW-1:0] lenv;
    sev = rst_n && snooper_done && st[sp] == 0;
    cev = rst_n && (cpu_acc || cpu_rej) && st[cp] == 1;
    fev = rst_n && ((fwd_done && st[fp] == 2) || st[fp] == 3);
    rej = cpu_rej;
    lenv = snooper_len;
    if (rst_n && snooper_wr_en && st[sp] == 0)
      for (int k = 0; k < 8; k++) mem_m[sp][int'(snooper_wr_addr) * 8 + k] = snooper_wr_data[63-8*k -: 8];
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        st[b] = 0;
        len_m[b] = '0;
      end
      sp = 0; cp = 0; fp = 0;
    end else begin
      if (sev) begin st[sp] = 1; len_m[sp] = lenv; sp = (sp + 1) % NB; end
      if (cev) begin st[cp] = rej ? 3 : 2; cp = (cp + 1) % NB; end
      if (fev) begin st[fp] = 0; fp = (fp + 1) % NB; end
    end
    snooper_wr_en = 0; snooper_done = 0; cpu_rd_en = 0; cpu_acc = 0; cpu_rej = 0;
    fwd_rd_en = 0; fwd_done = 0;
    #1;
  endtask

  function automatic logic [31:0] exp_cpu(input int ba, input int tsz);
    logic [31:0] w;
    if (st[cp] != 1 || tsz == 3) return 32'h0;
    w = {mem_m[cp][ba % NBYTES], mem_m[cp][(ba + 1) % NBYTES],
         mem_m[cp][(ba + 2) % NBYTES], mem_m[cp][(ba + 3) % NBYTES]};
    return tsz == 2 ? w : tsz == 1 ? {16'h0, w[31:16]} : {24'h0, w[31:24]};
  endfunction

  function automatic logic [63:0] exp_fwd(input int wa);
    logic [63:0] w;
    if (st[fp] != 2) return 64'h0;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = mem_m[fp][wa * 8 + k];
    return w;
  endfunction

  task automatic write_word(input int wa, input logic [63:0] d);
    snooper_wr_addr = AW'(wa);
    snooper_wr_data = d;
    snooper_wr_en = 1;
    cycle();
  endtask

  task automatic done(input int len);
    snooper_len = LW'(len);
    snooper_done = 1;
    cycle();
  endtask

  task automatic fill_rand(input int len);
    for (int w = 0; w < 9; w++) write_word(w == 8 ? (1 << AW) - 1 : w, {$urandom, $urandom});
    done(len);
  endtask

  task automatic cpu_read(input int ba, input int tsz, input logic [31:0] e, input string tag);
    cpu_byte_rd_addr = (AW+3)'(ba);
    transfer_sz = 2'(tsz);
    cpu_rd_en = 1;
    cycle();
    chk({tag, ".valid_early"}, 64'(cpu_rd_valid), 64'h0);
    cycle();
    chk({tag, ".valid"}, 64'(cpu_rd_valid), 64'h1);
    chk({tag, ".data"}, 64'(cpu_rd_data), 64'(e));
  endtask

  task automatic fwd_read(input int wa, input logic [63:0] e, input string tag);
    fwd_rd_addr = AW'(wa);
    fwd_rd_en = 1;
    cycle();
    chk({tag, ".valid"}, 64'(fwd_rd_valid), 64'h1);
    chk({tag, ".data"}, fwd_rd_data, e);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 0;
    cycle();
    check_state(tag);
    chk({tag, ".cpu_valid"}, 64'(cpu_rd_valid), 64'h0);
    chk({tag, ".fwd_valid"}, 64'(fwd_rd_valid), 64'h0);
    chk({tag, ".cpu_data"}, 64'(cpu_rd_data), 64'h0);
    chk({tag, ".fwd_data"}, fwd_rd_data, 64'h0);
    rst_n = 1;
    cycle();
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin st[b] = 0; len_m[b] = '0; end
    rst_n = 0;
    cycle();
    apply_reset("reset");
    chk("reset.ready_const", 64'(snooper_ready), 64'h1);

    // big-endian extraction
    write_word(0, 64'h0011223344556677);
    write_word(1, 64'h8899AABBCCDDEEFF);
    done(16);
    chk("be.cpu_avail", 64'(cpu_pkt_avail), 64'h1);
    chk("be.cpu_len", 64'(cpu_len), 64'd16);
    cpu_read(6, 2, 32'h66778899, "be_word");
    cpu_read(1, 1, 32'h00001122, "be_half");
    cpu_read(15, 0, 32'h000000FF, "be_byte");
    cpu_read(2, 3, 32'h0, "be_rsvd");
    fwd_read(0, 64'h0, "fwd_noown");
    cpu_acc = 1;
    cycle();
    check_state("be.acc");
    fwd_read(1, 64'h8899AABBCCDDEEFF, "fwd_w1");
    cpu_read(0, 2, 32'h0, "cpu_noown");
    fwd_done = 1;
    cycle();
    check_state("be.fwd_done");

    // full back-pressure, then simultaneous events
    apply_reset("rst2");
    fill_rand(20);
    fill_rand(30);
    fill_rand(40);
    chk("full.ready", 64'(snooper_ready), 64'h0);
    write_word(0, 64'hDEADBEEFDEADBEEF);
    done(99);
    chk("full.cpu_len", 64'(cpu_len), 64'd20);
    cpu_read(0, 2, exp_cpu(0, 2), "full_rd");
    cpu_acc = 1;
    cycle();
    fwd_done = 1;
    cycle();
    chk("full.ready_back", 64'(snooper_ready), 64'h1);
    check_state("full.freed");
    cpu_acc = 1;
    cycle();
    check_state("sim.pre");
    snooper_len = LW'(55);
    snooper_done = 1; cpu_acc = 1; cpu_rej = 1; fwd_done = 1;
    cycle();
    check_state("sim.post");
    chk("sim.cpu_len", 64'(cpu_len), 64'd55);
    chk("sim.fwd_avail", 64'(fwd_pkt_avail), 64'h0);
    cycle();
    check_state("sim.drain");

    // accept / reject ordering
    apply_reset("rst3");
    fill_rand(11);
    fill_rand(22);
    fill_rand(33);
    cpu_acc = 1; cycle();
    cpu_rej = 1; cycle();
    cpu_acc = 1; cycle();
    chk("ord.fwd_a", 64'(fwd_len), 64'd11);
    fwd_read(3, exp_fwd(3), "ord_rd_a");
    fwd_done = 1; cycle();
    chk("ord.b_hidden", 64'(fwd_pkt_avail), 64'h0);
    cycle();
    chk("ord.fwd_c_avail", 64'(fwd_pkt_avail), 64'h1);
    chk("ord.fwd_c", 64'(fwd_len), 64'd33);
    check_state("ord.c");
    fwd_read(5, exp_fwd(5), "ord_rd_c");

    // reset in the middle of reads
    apply_reset("rst4");
    fill_rand(10);
    cpu_acc = 1; cycle();
    fill_rand(12);
    cpu_byte_rd_addr = (AW+3)'(3); transfer_sz = 2'd2;
    cpu_rd_en = 1; fwd_rd_en = 1;
    cycle();
    rst_n = 0; cpu_rd_en = 1; fwd_rd_en = 1;
    cycle();
    chk("mid.cpu_valid", 64'(cpu_rd_valid), 64'h0);
    chk("mid.fwd_valid", 64'(fwd_rd_valid), 64'h0);
    chk("mid.cpu_avail", 64'(cpu_pkt_avail), 64'h0);
    chk("mid.fwd_avail", 64'(fwd_pkt_avail), 64'h0);
    chk("mid.ready", 64'(snooper_ready), 64'h1);
    rst_n = 1;
    cycle();
    chk("mid.cpu_valid2", 64'(cpu_rd_valid), 64'h0);
    fill_rand(41);
    chk("mid.ptr0_len", 64'(cpu_len), 64'd41);

    // random traffic
    apply_reset("rst5");
    for (int n = 0; n < 400; n++) begin
      int op, w;
      op = $urandom_range(0, 5);
      w = $urandom_range(0, 7);
      if (op == 0) begin
        if (st[sp] == 0) fill_rand($urandom_range(1, 72));
        else cycle();
      end else if (op == 1) begin
        cpu_acc = 1'($urandom_range(0, 1));
        cpu_rej = !cpu_acc;
        cycle();
      end else if (op == 2) begin
        fwd_done = 1;
        cycle();
      end else if (op == 3) begin
        int ba, tsz;
        ba = (w == 7 ? (1 << AW) - 1 : w) * 8 + $urandom_range(0, 7);
        tsz = $urandom_range(0, 3);
        cpu_read(ba, tsz, exp_cpu(ba, tsz), "rnd_cpu");
      end else if (op == 4) begin
        int wa;
        wa = $urandom_range(0, 8);
        wa = wa == 8 ? (1 << AW) - 1 : wa;
        fwd_read(wa, exp_fwd(wa), "rnd_fwd");
      end else begin
        cpu_acc = 1'($urandom_range(0, 1));
        cpu_rej = 1'($urandom_range(0, 1));
        fwd_done = 1'($urandom_range(0, 1));
        cycle();
      end
      check_state("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
